// File: rtl/regfile_wb_queue.sv
// ---------------------------------------------------------------------------
// regfile_wb_queue
//   Write-back initiator for the 32-entry register file. Result requests from
//   the execute and load paths are buffered in a small circular FIFO and
//   drained one per cycle onto the register file write port whenever that
//   port is granted. A combinational lookup exposes the youngest pending value
//   for any register, so read-side logic never sees a stale register file.
//
// Ports
//   clk         rising-edge clock
//   rst_n       synchronous active-low reset
//   in_valid    producer has a write-back request
//   in_ready    queue can accept a request this cycle (count < DEPTH)
//   in_reg      destination register index (index 0 is consumed, not stored)
//   in_data     value to write
//   wb_en       register file write port granted this cycle
//   RegWrite    write strobe to register file (pops the head entry)
//   w_reg       register file write index (head entry, else 0)
//   write_data  register file write data (head entry, else 0)
//   fwd_reg     register index being looked up by read logic
//   fwd_hit     a pending entry targets fwd_reg
//   fwd_data    youngest pending value for fwd_reg, else 0
//   count       current number of valid entries
// ---------------------------------------------------------------------------
module regfile_wb_queue #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [4:0]               in_reg,
  input  logic [WIDTH-1:0]         in_data,
  input  logic                     wb_en,
  output logic                     RegWrite,
  output logic [4:0]               w_reg,
  output logic [WIDTH-1:0]         write_data,
  input  logic [4:0]               fwd_reg,
  output logic                     fwd_hit,
  output logic [WIDTH-1:0]         fwd_data,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef struct packed {
    logic [4:0]       rd;
    logic [WIDTH-1:0] data;
  } entry_t;

  entry_t           mem_q [DEPTH];
  logic [DEPTH-1:0] valid_q, valid_d;
  logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    count_q, count_d;

  logic   push, pop, not_empty;
  entry_t head;

  assign not_empty = (count_q != '0);
  assign in_ready  = (count_q < CW'(DEPTH));
  // Register 0 requests complete the handshake but are never stored.
  assign push      = in_valid && in_ready && (in_reg != 5'd0);
  // Gated by rst_n so no write leaves the queue in the cycle reset is sampled.
  assign pop       = not_empty && wb_en && rst_n;

  assign head       = mem_q[rd_ptr_q];
  assign RegWrite   = pop;
  assign w_reg      = not_empty ? head.rd   : 5'd0;
  assign write_data = not_empty ? head.data : '0;
  assign count      = count_q;

  // NOTE: every variable written in always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    count_d = count_q;
    if (push && !pop) count_d = count_q + 1'b1;
    else if (!push && pop) count_d = count_q - 1'b1;

    // Push and pop never hit the same slot: that would need count == 0,
    // where no pop is possible.
    valid_d = valid_q;
    if (pop)  valid_d[rd_ptr_q] = 1'b0;
    if (push) valid_d[wr_ptr_q] = 1'b1;
  end

  // Forwarding: walk entries oldest to youngest so a later match overrides an
  // earlier one. The head being popped this cycle still matches, because the
  // register file has not captured it yet.
  always_comb begin
    logic [PW-1:0] idx;
    fwd_hit  = 1'b0;
    fwd_data = '0;
    idx      = '0;
    for (int k = 0; k < DEPTH; k++) begin
      idx = rd_ptr_q + PW'(k);
      if ((CW'(k) < count_q) && valid_q[idx] && (fwd_reg != 5'd0) &&
          (mem_q[idx].rd == fwd_reg)) begin
        fwd_hit  = 1'b1;
        fwd_data = mem_q[idx].data;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples its next value from the same pre-edge snapshot.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      valid_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_d;
      valid_q <= valid_d;
    end
  end

  // NOTE: the entry payload is not reset; it is only ever observed through a
  // valid bit or count, both of which are cleared, so a reset would only
  // cost fan-out on the storage array.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= '{rd: in_reg, data: in_data};
  end

endmodule

// File: tb/tb_regfile_wb_queue.sv
// ---------------------------------------------------------------------------
// tb_regfile_wb_queue
//   Directed self-checking bench for regfile_wb_queue (WIDTH=32, DEPTH=4).
//   Inputs change 1 time unit after a rising edge; outputs are compared one
//   further time unit later, well away from the edge.
// ---------------------------------------------------------------------------
module tb_regfile_wb_queue;

  localparam int WIDTH = 32;
  localparam int DEPTH = 4;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [4:0]       in_reg;
  logic [WIDTH-1:0] in_data;
  logic             wb_en;
  logic             RegWrite;
  logic [4:0]       w_reg;
  logic [WIDTH-1:0] write_data;
  logic [4:0]       fwd_reg;
  logic             fwd_hit;
  logic [WIDTH-1:0] fwd_data;
  logic [$clog2(DEPTH):0] count;

  int checks   = 0;
  int failures = 0;

  regfile_wb_queue #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_reg     (in_reg),
    .in_data    (in_data),
    .wb_en      (wb_en),
    .RegWrite   (RegWrite),
    .w_reg      (w_reg),
    .write_data (write_data),
    .fwd_reg    (fwd_reg),
    .fwd_hit    (fwd_hit),
    .fwd_data   (fwd_data),
    .count      (count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Advance one clock; inputs may be changed right after return.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Let combinational outputs settle after an input change.
  task automatic settle();
    #1;
  endtask

  task automatic push_one(input logic [4:0] r, input logic [WIDTH-1:0] d);
    in_valid = 1'b1;
    in_reg   = r;
    in_data  = d;
    tick();
    in_valid = 1'b0;
  endtask

  initial begin
    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_reg   = '0;
    in_data  = '0;
    wb_en    = 1'b0;
    fwd_reg  = '0;

    // ---- Reset then idle --------------------------------------------------
    tick();
    tick();
    rst_n = 1'b1;
    wb_en = 1'b1;
    fwd_reg = 5'd5;
    settle();
    check("rst_in_ready",   in_ready,   1);
    check("rst_regwrite",   RegWrite,   0);
    check("rst_count",      count,      0);
    check("rst_fwd_hit",    fwd_hit,    0);
    check("rst_fwd_data",   fwd_data,   0);
    check("rst_w_reg",      w_reg,      0);
    check("rst_write_data", write_data, 0);

    // ---- Single write -----------------------------------------------------
    in_valid = 1'b1;
    in_reg   = 5'd5;
    in_data  = 32'hDEADBEEF;
    settle();
    check("single_no_bypass", RegWrite, 0);
    tick();
    in_valid = 1'b0;
    settle();
    check("single_regwrite", RegWrite,   1);
    check("single_w_reg",    w_reg,      5);
    check("single_data",     write_data, 32'hDEADBEEF);
    check("single_count",    count,      1);
    check("single_pop_hit",  fwd_hit,    1);
    check("single_pop_fwd",  fwd_data,   32'hDEADBEEF);
    tick();
    settle();
    check("single_after_count", count,    0);
    check("single_after_rw",    RegWrite, 0);

    // ---- Fill and stall ---------------------------------------------------
    wb_en = 1'b0;
    for (int i = 1; i <= 4; i++) push_one(5'(i), 32'(8'h11 * i));
    settle();
    check("fill_count",    count,    4);
    check("fill_in_ready", in_ready, 0);
    check("fill_regwrite", RegWrite, 0);
    // A request against a full queue must not be taken.
    push_one(5'd9, 32'h99);
    settle();
    check("full_reject_count", count, 4);
    fwd_reg = 5'd9;
    settle();
    check("full_reject_fwd", fwd_hit, 0);
    // Full with a pop this cycle: in_ready still reflects the registered count.
    wb_en = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      settle();
      check($sformatf("drain%0d_rw", i),   RegWrite,   1);
      check($sformatf("drain%0d_reg", i),  w_reg,      i);
      check($sformatf("drain%0d_data", i), write_data, 8'h11 * i);
      if (i == 1) check("drain_full_in_ready", in_ready, 0);
      tick();
    end
    settle();
    check("drain_done_count", count,    0);
    check("drain_done_rw",    RegWrite, 0);

    // ---- Register 0 drop --------------------------------------------------
    in_valid = 1'b1;
    in_reg   = 5'd0;
    in_data  = 32'hFFFF;
    fwd_reg  = 5'd0;
    settle();
    check("r0_in_ready", in_ready, 1);
    tick();
    in_valid = 1'b0;
    settle();
    check("r0_count",   count,    0);
    check("r0_rw",      RegWrite, 0);
    check("r0_fwd_hit", fwd_hit,  0);

    // ---- Forwarding youngest ----------------------------------------------
    wb_en = 1'b0;
    push_one(5'd7, 32'hA);
    push_one(5'd3, 32'hB);
    push_one(5'd7, 32'hC);
    fwd_reg = 5'd7;
    settle();
    check("fwd7_hit",  fwd_hit,  1);
    check("fwd7_data", fwd_data, 32'hC);
    fwd_reg = 5'd3;
    settle();
    check("fwd3_hit",  fwd_hit,  1);
    check("fwd3_data", fwd_data, 32'hB);
    fwd_reg = 5'd9;
    settle();
    check("fwd9_hit",  fwd_hit,  0);
    check("fwd9_data", fwd_data, 0);
    check("fwd_count", count,    3);
    // Same-register writes commit in arrival order.
    wb_en = 1'b1;
    settle();
    check("fwd_pop1_reg",  w_reg,      7);
    check("fwd_pop1_data", write_data, 32'hA);
    tick();
    settle();
    check("fwd_pop2_reg",  w_reg,      3);
    tick();
    settle();
    check("fwd_pop3_reg",  w_reg,      7);
    check("fwd_pop3_data", write_data, 32'hC);
    tick();
    settle();
    check("fwd_empty", count, 0);

    // ---- Simultaneous push/pop with wrap ----------------------------------
    wb_en = 1'b0;
    push_one(5'd10, 32'h100);
    push_one(5'd11, 32'h101);
    wb_en    = 1'b1;
    in_valid = 1'b1;
    for (int j = 0; j < 6; j++) begin
      in_reg  = 5'(12 + j);
      in_data = 32'(32'h102 + j);
      settle();
      check($sformatf("pp%0d_count", j), count,      2);
      check($sformatf("pp%0d_rw", j),    RegWrite,   1);
      check($sformatf("pp%0d_reg", j),   w_reg,      10 + j);
      check($sformatf("pp%0d_data", j),  write_data, 32'h100 + j);
      tick();
    end
    in_valid = 1'b0;
    wb_en    = 1'b0;
    settle();
    check("pp_end_count", count, 2);
    check("pp_end_head",  w_reg, 16);
    push_one(5'd18, 32'h108);
    settle();
    check("pre_rst_count", count, 3);

    // ---- Mid-operation reset ----------------------------------------------
    rst_n = 1'b0;
    wb_en = 1'b1;
    settle();
    check("rst_cycle_no_write", RegWrite, 0);
    tick();
    rst_n   = 1'b1;
    fwd_reg = 5'd16;
    settle();
    check("midrst_count",    count,    0);
    check("midrst_rw",       RegWrite, 0);
    check("midrst_in_ready", in_ready, 1);
    check("midrst_fwd_hit",  fwd_hit,  0);
    for (int k = 0; k < 4; k++) begin
      tick();
      check($sformatf("midrst_stale%0d", k), RegWrite, 0);
    end
    // Queue is usable again after reset, starting from slot 0.
    push_one(5'd20, 32'h55AA);
    settle();
    check("post_rst_reg",  w_reg,      20);
    check("post_rst_data", write_data, 32'h55AA);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
